// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl
// Sits between the UART receiver/transmitter and the 0..9999 counter.
// Received ASCII bytes are decoded into counter controls:
//   R/r toggles the run level, C/c pulses clear, Q/q requests a report.
// A report sends the count as four ASCII decimal digits, optionally
// followed by CR LF, one byte per transmitter busy period.
//
// Ports:
//   clk           system clock
//   rst           synchronous active-high reset
//   rx_data       received byte, valid with rx_done
//   rx_done       one-cycle strobe, byte received
//   tx_busy       transmitter busy flag
//   count_val     current counter value (binary)
//   tx_start      one-cycle strobe to the transmitter
//   tx_data       byte to transmit, held until the next byte is loaded
//   o_run         counter enable level
//   o_clear       one-cycle counter clear pulse
//   o_query_busy  high while a report is in progress
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no report running; a query starts one
// LOAD    | present byte[index] on tx_data, wait for transmitter idle
// START   | raise tx_start for one cycle
// WAIT_HI | wait for the transmitter to go busy
// WAIT_LO | wait for the transmitter to finish the byte
// NEXT    | advance index or finish the report

module uart_cmd_ctrl #(
    parameter int CNT_MAX     = 9999,
    parameter bit LINE_END_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_done,
    input  logic        tx_busy,
    input  logic [13:0] count_val,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic        o_run,
    output logic        o_clear,
    output logic        o_query_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT_HI,
        S_WAIT_LO,
        S_NEXT
    } state_t;

    localparam logic [13:0] CNT_MAX_V = 14'(CNT_MAX);
    localparam logic [2:0]  LAST_IDX  = LINE_END_EN ? 3'd5 : 3'd3;

    state_t      state;
    logic [2:0]  idx;
    logic [7:0]  digit_q [0:3];

    logic        cmd_r;
    logic        cmd_c;
    logic        cmd_q;
    logic [13:0] snap_v;
    logic [3:0]  d_th;
    logic [3:0]  d_hu;
    logic [3:0]  d_te;
    logic [3:0]  d_on;
    logic [7:0]  cur_byte;

    assign cmd_r = rx_done && ((rx_data == 8'h52) || (rx_data == 8'h72));
    assign cmd_c = rx_done && ((rx_data == 8'h43) || (rx_data == 8'h63));
    assign cmd_q = rx_done && ((rx_data == 8'h51) || (rx_data == 8'h71));

    // Saturate before splitting so an over-range count reports as CNT_MAX.
    assign snap_v = (count_val > CNT_MAX_V) ? CNT_MAX_V : count_val;
    assign d_th   = 4'(snap_v / 14'd1000);
    assign d_hu   = 4'((snap_v / 14'd100) % 14'd10);
    assign d_te   = 4'((snap_v / 14'd10) % 14'd10);
    assign d_on   = 4'(snap_v % 14'd10);

    always_comb begin
        cur_byte = 8'h00;
        case (idx)
            3'd0, 3'd1, 3'd2, 3'd3: cur_byte = digit_q[idx[1:0]];
            3'd4:                   cur_byte = 8'h0D;
            3'd5:                   cur_byte = 8'h0A;
            default:                cur_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            idx          <= 3'd0;
            tx_start     <= 1'b0;
            tx_data      <= 8'h00;
            o_run        <= 1'b0;
            o_clear      <= 1'b0;
            o_query_busy <= 1'b0;
            for (int i = 0; i < 4; i++) digit_q[i] <= 8'h30;
        end else begin
            tx_start <= 1'b0;
            o_clear  <= 1'b0;

            // Run/clear are honoured in every state, including mid-report.
            if (cmd_r) o_run   <= ~o_run;
            if (cmd_c) o_clear <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (cmd_q) begin
                        digit_q[0]   <= 8'h30 + {4'h0, d_th};
                        digit_q[1]   <= 8'h30 + {4'h0, d_hu};
                        digit_q[2]   <= 8'h30 + {4'h0, d_te};
                        digit_q[3]   <= 8'h30 + {4'h0, d_on};
                        idx          <= 3'd0;
                        o_query_busy <= 1'b1;
                        state        <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    tx_data <= cur_byte;
                    if (!tx_busy) state <= S_START;
                end
                S_START: begin
                    // Re-check busy so a start can never overlap a busy transmitter.
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        state    <= S_WAIT_HI;
                    end else begin
                        state <= S_LOAD;
                    end
                end
                S_WAIT_HI: begin
                    if (tx_busy) state <= S_WAIT_LO;
                end
                S_WAIT_LO: begin
                    if (!tx_busy) state <= S_NEXT;
                end
                S_NEXT: begin
                    if (idx == LAST_IDX) begin
                        o_query_busy <= 1'b0;
                        state        <= S_IDLE;
                    end else begin
                        idx   <= idx + 3'd1;
                        state <= S_LOAD;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Testbench for uart_cmd_ctrl: a transmitter model answers each tx_start
// with a 10-cycle busy period; expected report bytes are queued when a
// query is sent and popped as tx_start pulses appear.

module tb_uart_cmd_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic        tx_busy;
    logic [13:0] count_val;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        o_run;
    logic        o_clear;
    logic        o_query_busy;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          q_cyc = 0;
    int          last_rx_cyc = 0;
    int          n_start = 0;
    int          rep_starts = 0;
    bit          lat_pending = 1'b0;
    bit          busy_seen = 1'b1;
    int          tcnt = 0;
    logic [7:0]  exp_q [$];

    uart_cmd_ctrl #(.CNT_MAX(9999), .LINE_END_EN(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_done      (rx_done),
        .tx_busy      (tx_busy),
        .count_val    (count_val),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .o_run        (o_run),
        .o_clear      (o_clear),
        .o_query_busy (o_query_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter model: busy rises two cycles after tx_start, lasts 10 cycles.
    always @(posedge clk) begin
        if (rst)           tcnt <= 0;
        else if (tx_start) tcnt <= 12;
        else if (tcnt != 0) tcnt <= tcnt - 1;
    end
    assign tx_busy = (tcnt != 0) && (tcnt <= 10);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [7:0] e;
        if (rst) busy_seen = 1'b1;
        if (tx_busy) busy_seen = 1'b1;
        if (tx_start) begin
            chk("start_while_busy", tx_busy, 0);
            chk("busy_cycle_between_starts", busy_seen, 1);
            busy_seen = 1'b0;
            n_start++;
            rep_starts++;
            if (lat_pending) begin
                chk("query_latency", cyc - q_cyc, 3);
                lat_pending = 1'b0;
            end
            chk("exp_byte_avail", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("tx_byte", tx_data, e);
            end
        end
    end

    task automatic send_rx(input logic [7:0] b);
        @(posedge clk); #1;
        rx_data     = b;
        rx_done     = 1'b1;
        last_rx_cyc = cyc;
        @(posedge clk); #1;
        rx_done = 1'b0;
    endtask

    task automatic push_report(input int cv);
        int    v;
        string s;
        v = (cv > 9999) ? 9999 : cv;
        s = $sformatf("%04d", v);
        for (int i = 0; i < 4; i++) exp_q.push_back(s[i]);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic query(input int cv);
        count_val  = 14'(cv);
        push_report(cv);
        rep_starts = 0;
        send_rx(8'h71);
        q_cyc       = last_rx_cyc;
        lat_pending = 1'b1;
    endtask

    task automatic wait_starts(input int n);
        for (int i = 0; i < 300 && rep_starts < n; i++) @(posedge clk);
        #1;
        chk("reached_starts", rep_starts >= n, 1);
    endtask

    task automatic wait_report();
        for (int i = 0; i < 400 && o_query_busy; i++) @(posedge clk);
        #1;
        chk("report_done", o_query_busy, 0);
        chk("bytes_left", exp_q.size(), 0);
    endtask

    initial begin
        rst       = 1'b1;
        rx_data   = 8'h00;
        rx_done   = 1'b0;
        count_val = 14'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        repeat (20) @(posedge clk);
        #1;
        chk("idle_tx_start", tx_start, 0);
        chk("idle_tx_data", tx_data, 8'h00);
        chk("idle_run", o_run, 0);
        chk("idle_clear", o_clear, 0);
        chk("idle_qbusy", o_query_busy, 0);
        chk("idle_no_starts", n_start, 0);

        send_rx("r");
        chk("run_on", o_run, 1);
        send_rx("R");
        chk("run_off", o_run, 0);
        send_rx("x");
        chk("ignore_x_run", o_run, 0);
        chk("ignore_x_clear", o_clear, 0);
        send_rx("r");
        chk("run_on2", o_run, 1);

        send_rx("c");
        chk("clear_pulse", o_clear, 1);
        chk("clear_keeps_run", o_run, 1);
        @(posedge clk); #1;
        chk("clear_one_cycle", o_clear, 0);
        chk("clear_run_after", o_run, 1);

        // Report 1234; count changes, extra query and run toggle mid-report.
        query(1234);
        chk("qbusy_set", o_query_busy, 1);
        wait_starts(1);
        count_val = 14'd5;
        send_rx("q");
        send_rx("r");
        chk("run_toggle_mid_report", o_run, 0);
        chk("qbusy_mid_report", o_query_busy, 1);
        wait_report();
        chk("report1_bytes", rep_starts, 6);

        query(12000);
        wait_report();
        chk("report_sat_bytes", rep_starts, 6);

        query(7);
        wait_report();
        chk("report_small_bytes", rep_starts, 6);

        // Reset after the second byte aborts the report.
        query(42);
        wait_starts(2);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        exp_q.delete();
        begin
            int n0;
            n0 = n_start;
            repeat (40) @(posedge clk);
            #1;
            chk("no_start_after_rst", n_start, n0);
        end
        chk("rst_qbusy", o_query_busy, 0);
        chk("rst_tx_data", tx_data, 8'h00);
        chk("rst_run", o_run, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
- Command controller between the UART loopback datapath (rx byte/done strobes in, tx start/data out) and the 0–9999 counter.
- Decodes received ASCII bytes into run/stop/clear controls for the counter.
- On a query, sequences the UART transmitter to send the current count as 4 ASCII decimal digits, optionally followed by CR LF.
- Replaces the direct rx_done→tx_start loopback wiring in the UART top level.

Parameters:
- CNT_MAX, 9999: largest reportable count; count_val above this is reported as CNT_MAX.
- LINE_END_EN, 1: 1 = append CR (8'h0D) and LF (8'h0A) after the digits (6 bytes); 0 = digits only (4 bytes).

Ports:
- clk  input  1  system clock, 100 MHz
- rst  input  1  synchronous, active-high reset
- rx_data  input  8  received byte; valid when rx_done=1
- rx_done  input  1  one-cycle strobe, byte received
- tx_busy  input  1  transmitter busy flag
- count_val  input  14  current counter value, binary
- tx_start  output  1  one-cycle strobe to transmitter
- tx_data  output  8  byte to transmit; held stable from tx_start until the next byte is loaded
- o_run  output  1  counter enable level
- o_clear  output  1  one-cycle counter clear pulse
- o_query_busy  output  1  high while a report is in progress

Behaviour:
- Single clock. Reset is synchronous and active-high. All state is sampled on posedge clk.
- Reset values: tx_start=0, tx_data=8'h00, o_run=0, o_clear=0, o_query_busy=0, FSM=IDLE, byte index=0.
- Reset asserted mid-report aborts the report immediately. No further tx_start is issued.
- Command decode happens on the rx_done=1 cycle. Case-insensitive.
  - 'R'/'r' (8'h52/8'h72): toggle o_run, registered, effective the next cycle.
  - 'C'/'c' (8'h43/8'h63): o_clear=1 for exactly one cycle, the cycle after rx_done. o_run is unchanged.
  - 'Q'/'q' (8'h51/8'h71): start a report if FSM=IDLE. Otherwise the query is dropped (no queuing).
  - Any other byte is ignored with no output change.
- R and C are honoured in every FSM state, including during a report.
- Report snapshot, taken on query acceptance:
  - v = min(count_val, CNT_MAX).
  - Split v into thousands/hundreds/tens/ones digits; each digit = 8'h30 + d.
  - Store all digits in registers. Later count_val changes do not affect the report in progress.
- Report FSM:
  - IDLE: query accepted → LOAD, index=0, o_query_busy=1.
  - LOAD: tx_data = byte[index] (digits MSB first, then CR, LF). If tx_busy=0 → START; else stay.
  - START: tx_start=1 for one cycle → WAIT_HI.
  - WAIT_HI: wait for tx_busy=1 → WAIT_LO. The transmitter raises busy within a few cycles of tx_start.
  - WAIT_LO: wait for tx_busy=0 → NEXT.
  - NEXT: if index = last (3, or 5 with LINE_END_EN) → IDLE and o_query_busy=0; else index+1 → LOAD.
- Ordering guarantees:
  - tx_start is never asserted while tx_busy=1.
  - Consecutive tx_start pulses are separated by at least one full busy high→low cycle.
- Latency: query rx_done at cycle N → first tx_start at N+3 when tx_busy=0.
- Simultaneous events:
  - A query arriving on the same cycle NEXT returns to IDLE is dropped; IDLE must be registered first.
  - rx_done with any byte during the report does not disturb tx_data or the index.

Test Plan:
- Reset, then idle 20 cycles → all outputs 0, no tx_start.
- rx 'r' → o_run=1 one cycle later; rx 'R' → o_run=0; rx 'x' → no change.
- o_run=1, rx 'c' → o_clear high exactly 1 cycle, o_run stays 1.
- count_val=1234, rx 'q', transmitter model busy for 10 cycles per byte → tx bytes 0x31,0x32,0x33,0x34,0x0D,0x0A in order. Check one tx_start per busy period and no tx_start while busy. Change count_val to 5 mid-report → report unchanged.
- count_val=12000 → bytes "9999"+CR LF. count_val=7 → "0007".
- Second 'q' mid-report → dropped (exactly 6 bytes total). 'r' mid-report → o_run toggles while the report continues. rst after the 2nd byte → no further tx_start, o_query_busy=0.
